card_shoe: RTL and testbench
============================

# card_shoe

Parametrised multi-deck card dealer, the successor to the single-shot card generator in the blackjack datapath. Holds a finite shoe of `NUM_DECKS` decks and draws cards without replacement using a free-running LFSR. Deals one or two cards per request over a req/valid handshake, and reshuffles automatically when the shoe runs low. Scripted test modes replay fixed card sequences for the game-controller benches.

## Interface
- `NUM_DECKS`, default 1: decks in shoe, legal range 1..8.
- `LFSR_W`, default 16: LFSR width, fixed polynomial x^16+x^14+x^13+x^11+1.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `RESHUFFLE_AT`, default 15: reshuffle when remaining cards < this value.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in 1: deal request, sampled only in IDLE.
- `two` in 1: 1 = deal two cards, 0 = deal one; sampled with `req`.
- `test` in 3: mode; 0 BASE (random), 1 SIMPLE, 2 DOUBLE, 3 BLACKJACK, 4 SPLIT, other values are illegal.
- `card1_out` out 4: first card value 1..10 (ace = 1, J/Q/K = 10); 0 = none.
- `card2_out` out 4: second card value; 0 when one card is dealt.
- `valid` out 1: one-cycle pulse, cards are valid.
- `busy` out 1: high in every state except IDLE.
- `shuffled` out 1: one-cycle pulse on completion of a reshuffle.
- `remaining` out RW = clog2(52·NUM_DECKS+1): cards left in shoe.

## Operation
- **Shoe storage:** 13 rank counters, ranks 1..13, each 6 bits wide. Full shoe is 4·NUM_DECKS per rank.
- **LFSR:** advances every cycle after reset, independent of state.
- **FSM states:** IDLE, SHUFFLE, DRAW1, DRAW2, DONE.
- **IDLE:**
  - If `remaining` < RESHUFFLE_AT, go to SHUFFLE. Precedence over `req`; the request is dropped.
  - Else on `req` with `test`==BASE, go to DRAW1.
  - Else on `req` with a script mode, load the script step into the card registers and go to DONE.
- **SHUFFLE (1 cycle):** reload all counters to full, set `remaining` to 52·NUM_DECKS, pulse `shuffled`, return to IDLE.
- **DRAW1 / DRAW2 acceptance:**
  - Candidate rank = `lfsr[3:0]`.
  - Accept if the candidate is 1..13 and its counter is nonzero; otherwise retry next cycle.
  - After 16 consecutive rejects, take the lowest nonzero rank.
  - On accept: decrement that counter and `remaining` in the same cycle, and latch the clamped value.
- **DRAW1 exits:** to DRAW2 if `two`, else to DONE.
- **Empty shoe mid-deal:** if `remaining` reaches 0 in DRAW1 with `two`=1, DRAW2 deals 0 to `card2_out` and goes to DONE. Unreachable while RESHUFFLE_AT ≥ 2.
- **DONE (1 cycle):** `valid`=1, then return to IDLE. Card outputs hold until the next DONE.
- **Script sequences** (per-mode step index; index wraps to 0 after the last step; every index clears when `test` changes):
  - SIMPLE: (10,8), (4,0).
  - DOUBLE: (10,8), (2,0).
  - BLACKJACK: (10,1).
  - SPLIT: (10,10), (8,0), (4,0), (8,0), (2,0).
- **Script side effects:** scripted deals ignore `two` and do not touch the shoe or `remaining`.
- **Busy requests:** `req` while `busy` is ignored and not queued.
- **Illegal `test`:** a request produces a DONE with cards (0,0).

## Timing
- **Reset values:** all outputs 0 except `remaining` = 52·NUM_DECKS. Counters full, LFSR = SEED, state IDLE, script indices 0.
- **Reset mid-deal:** abandons the deal with no `valid`.
- **Scripted latency:** `req` at edge N, `valid` high during cycle N+1.
- **Random latency:** minimum 2 cycles for one card, 3 for two. Each reject adds one cycle. Worst case per card is 17 cycles.
- **Reshuffle:** occupies 1 cycle plus the return to IDLE. A `req` at the edge where SHUFFLE is entered is lost.
- **Output registers:** `card*_out` and `remaining` are registered. `card*_out` changes only on entry to DONE; `remaining` changes on draw accept and in SHUFFLE.

## Structure
- **Package `card_pkg`:** test-mode codes, rank constants (ACE=1, KING=13), the clamp function (rank > 10 → 10), script tables with per-mode step counts, and the FSM state enum.
- **Sub-module `card_lfsr`:** Galois LFSR, parametrised by width and seed, with asynchronous reset. The top level holds the FSM, rank counters and script indices.

## Test plan
- **Reset:** assert `reset` mid-DRAW2 -> no `valid`; outputs 0; `remaining` = 52 (NUM_DECKS=1).
- **SPLIT script:** `test`=4, five requests -> cards (10,10), (8,0), (4,0), (8,0), (2,0), then wraps to (10,10); `remaining` unchanged.
- **Mode change:** `test`=1, one request -> (10,8); switch to 2 then back to 1, request -> (10,8), not (4,0).
- **Random shoe:** NUM_DECKS=1, BASE, `two`=1, issue requests until 38 cards are dealt:
  - per-rank counts never go negative;
  - no rank is dealt more than 4 times;
  - `remaining` decrements by 2 per deal;
  - `shuffled` pulses once `remaining` = 14 and the FSM returns to IDLE; `remaining` then reads 52.
- **Fallback draw:** force counters so only rank 13 is nonzero -> draw completes within 17 cycles; `card1_out` = 10.
- **Busy handling:** pulse `req` every cycle during a deal -> exactly one `valid` per accepted request; latencies match the Timing section.

Source files
------------

// File: rtl/card_pkg.sv
// Shared definitions for the card shoe: mode codes, rank constants,
// the face-card clamp, the scripted deal tables and the FSM state type.
package card_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHUFFLE = 3'd1,
      ST_DRAW1   = 3'd2,
      ST_DRAW2   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [2:0] TM_BASE   = 3'd0;
   localparam logic [2:0] TM_SIMPLE = 3'd1;
   localparam logic [2:0] TM_DOUBLE = 3'd2;
   localparam logic [2:0] TM_BJ     = 3'd3;
   localparam logic [2:0] TM_SPLIT  = 3'd4;

   localparam logic [3:0] RANK_ACE  = 4'd1;
   localparam logic [3:0] RANK_KING = 4'd13;

   // J/Q/K all score as ten
   function automatic logic [3:0] clamp_rank(input logic [3:0] r);
      return (r > 4'd10) ? 4'd10 : r;
   endfunction

   function automatic logic [2:0] script_len(input logic [2:0] m);
      case (m)
         TM_SIMPLE: return 3'd2;
         TM_DOUBLE: return 3'd2;
         TM_BJ:     return 3'd1;
         TM_SPLIT:  return 3'd5;
         default:   return 3'd1;
      endcase
   endfunction

   // returns {card1, card2}
   function automatic logic [7:0] script_step(input logic [2:0] m, input logic [2:0] s);
      logic [7:0] c;
      c = 8'h00;
      case (m)
         TM_SIMPLE: c = (s == 3'd0) ? {4'd10, 4'd8} : {4'd4, 4'd0};
         TM_DOUBLE: c = (s == 3'd0) ? {4'd10, 4'd8} : {4'd2, 4'd0};
         TM_BJ:     c = {4'd10, RANK_ACE};
         TM_SPLIT: begin
            case (s)
               3'd0:    c = {4'd10, 4'd10};
               3'd1:    c = {4'd8, 4'd0};
               3'd2:    c = {4'd4, 4'd0};
               3'd3:    c = {4'd8, 4'd0};
               default: c = {4'd2, 4'd0};
            endcase
         end
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Galois LFSR (right shift). Only the low nibble leaves the
// block since that is all the dealer uses as a candidate rank.
module card_lfsr #(
   parameter int           W    = 16,
   parameter logic [W-1:0] SEED = W'(16'hACE1),
   parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] rnd_o
);

   logic [W-1:0] lfsr_q, lfsr_d;

   // shift right, fold the tap mask in when a one falls off the end
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
   end

   // state register, advances every cycle out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign rnd_o = lfsr_q[3:0];

endmodule

// File: rtl/card_shoe.sv
// Multi-deck dealer: rank counters, draw-without-replacement FSM,
// automatic reshuffle and scripted replay modes.
//
//  state      | meaning
//  -----------+----------------------------------------------
//  IDLE       | wait for req; reshuffle first if shoe is low
//  SHUFFLE    | refill every rank counter, pulse shuffled
//  DRAW1      | search for first card (retry / fallback)
//  DRAW2      | search for second card
//  DONE       | present cards, pulse valid
module card_shoe
   import card_pkg::*;
#(
   parameter int                NUM_DECKS    = 1,
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] SEED         = LFSR_W'(16'hACE1),
   parameter int                RESHUFFLE_AT = 15
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req,
   input  logic                                 two,
   input  logic [2:0]                           test,
   output logic [3:0]                           card1_out,
   output logic [3:0]                           card2_out,
   output logic                                 valid,
   output logic                                 busy,
   output logic                                 shuffled,
   output logic [$clog2(52*NUM_DECKS+1)-1:0]    remaining
);

   localparam int             RW        = $clog2(52*NUM_DECKS+1);
   localparam logic [RW-1:0]  FULL_SHOE = RW'(52*NUM_DECKS);
   localparam logic [RW-1:0]  LOW_MARK  = RW'(RESHUFFLE_AT);
   localparam logic [5:0]     FULL_RANK = 6'(4*NUM_DECKS);

   state_t            state_q, state_d;
   logic [12:0][5:0]  cnt_q, cnt_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [3:0]        card1_q, card1_d, card2_q, card2_d, hold1_q, hold1_d;
   logic [4:0]        rej_q, rej_d;
   logic              two_q, two_d;
   logic [2:0]        test_q;
   logic [3:0][2:0]   idx_q, idx_d;

   logic [3:0]        cand, take, fb_rank, val;
   logic              cand_ok, accept, got;
   logic [1:0]        slot;
   logic [2:0]        step;
   logic [7:0]        scr;

   card_lfsr #(.W(LFSR_W), .SEED(SEED), .TAPS(LFSR_W'(16'hB400))) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .rnd_o (cand)
   );

   // candidate check, lowest-nonzero fallback, and the one draw result
   always_comb begin
      cand_ok = 1'b0;
      fb_rank = 4'd0;
      for (int r = 0; r < 13; r++)
         if (cand == 4'(r + 1) && cnt_q[r] != 6'd0) cand_ok = 1'b1;
      for (int r = 12; r >= 0; r--)
         if (cnt_q[r] != 6'd0) fb_rank = 4'(r + 1);
      take   = (rej_q == 5'd16) ? fb_rank : cand;
      accept = (rej_q == 5'd16) ? (fb_rank != 4'd0) : cand_ok;
   end

   // next-state, counters, script indices and card registers
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      card1_d = card1_q;
      card2_d = card2_q;
      hold1_d = hold1_q;
      rej_d   = rej_q;
      two_d   = two_q;
      idx_d   = (test != test_q) ? '0 : idx_q;
      slot    = test[1:0] - 2'd1;
      step    = idx_d[slot];
      scr     = script_step(test, step);
      val     = 4'd0;
      got     = 1'b0;

      if (state_q == ST_DRAW1 || state_q == ST_DRAW2) begin
         if (rem_q == '0) begin
            got = 1'b1;
         end else if (accept) begin
            got = 1'b1;
            val = clamp_rank(take);
            rem_d = rem_q - RW'(1);
            for (int r = 0; r < 13; r++)
               if (take == 4'(r + 1)) cnt_d[r] = cnt_q[r] - 6'd1;
         end else begin
            rej_d = rej_q + 5'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (rem_q < LOW_MARK) begin
               state_d = ST_SHUFFLE;
            end else if (req) begin
               two_d = two;
               rej_d = 5'd0;
               if (test == TM_BASE) begin
                  state_d = ST_DRAW1;
               end else if (test <= TM_SPLIT) begin
                  {card1_d, card2_d} = scr;
                  idx_d[slot] = (step + 3'd1 == script_len(test)) ? 3'd0 : step + 3'd1;
                  state_d = ST_DONE;
               end else begin
                  card1_d = 4'd0;
                  card2_d = 4'd0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_SHUFFLE: begin
            for (int r = 0; r < 13; r++) cnt_d[r] = FULL_RANK;
            rem_d   = FULL_SHOE;
            state_d = ST_IDLE;
         end
         ST_DRAW1: begin
            if (got) begin
               rej_d = 5'd0;
               if (two_q) begin
                  hold1_d = val;
                  state_d = ST_DRAW2;
               end else begin
                  card1_d = val;
                  card2_d = 4'd0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DRAW2: begin
            if (got) begin
               rej_d   = 5'd0;
               card1_d = hold1_q;
               card2_d = val;
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // all sequential state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         for (int r = 0; r < 13; r++) cnt_q[r] <= FULL_RANK;
         rem_q   <= FULL_SHOE;
         card1_q <= 4'd0;
         card2_q <= 4'd0;
         hold1_q <= 4'd0;
         rej_q   <= 5'd0;
         two_q   <= 1'b0;
         test_q  <= 3'd0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         card1_q <= card1_d;
         card2_q <= card2_d;
         hold1_q <= hold1_d;
         rej_q   <= rej_d;
         two_q   <= two_d;
         test_q  <= test;
         idx_q   <= idx_d;
      end
   end

   assign card1_out = card1_q;
   assign card2_out = card2_q;
   assign remaining = rem_q;
   assign valid     = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign shuffled  = (state_q == ST_SHUFFLE);

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe with NUM_DECKS=1 and default parameters.
module tb_card_shoe;
   import card_pkg::*;

   logic       clk = 1'b0;
   logic       reset, req, two;
   logic [2:0] test;
   logic [3:0] card1_out, card2_out;
   logic       valid, busy, shuffled;
   logic [5:0] remaining;

   int total = 0;
   int bad   = 0;
   int vcount = 0;

   typedef struct {
      logic [3:0] c1;
      logic [3:0] c2;
   } exp_t;
   exp_t exp_q[$];

   card_shoe dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .two       (two),
      .test      (test),
      .card1_out (card1_out),
      .card2_out (card2_out),
      .valid     (valid),
      .busy      (busy),
      .shuffled  (shuffled),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (valid === 1'b1) vcount++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // drive one request from IDLE, wait for valid, leave the FSM back in IDLE
   task automatic deal(input logic two_v, output int lat, output logic [3:0] c1, output logic [3:0] c2);
      req = 1'b1;
      two = two_v;
      tick();
      req = 1'b0;
      lat = 1;
      while (valid !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
      c1 = card1_out;
      c2 = card2_out;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; two = 1'b0; test = TM_BASE;
      tick();
      tick();
      total++;
      if ({card1_out, card2_out, valid, busy, shuffled} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h required 0", {card1_out, card2_out, valid, busy, shuffled});
      end
      total++;
      if (remaining !== 6'd52) begin
         bad++;
         $display("FAIL reset_remaining: got %0d required 52", remaining);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_split();
      exp_t e, g;
      int lat;
      logic [3:0] c1, c2;
      logic [7:0] tbl [6];
      tbl = '{8'hAA, 8'h80, 8'h40, 8'h80, 8'h20, 8'hAA};
      do_reset();
      test = TM_SPLIT;
      tick();
      for (int i = 0; i < 6; i++) begin
         e.c1 = tbl[i][7:4];
         e.c2 = tbl[i][3:0];
         exp_q.push_back(e);
         deal(1'b1, lat, c1, c2);
         g = exp_q.pop_front();
         total++;
         if (c1 !== g.c1 || c2 !== g.c2) begin
            bad++;
            $display("FAIL split_step%0d: got (%0d,%0d) required (%0d,%0d)", i, c1, c2, g.c1, g.c2);
         end
         total++;
         if (lat != 1) begin
            bad++;
            $display("FAIL split_latency%0d: got %0d required 1", i, lat);
         end
      end
      total++;
      if (remaining !== 6'd52) begin
         bad++;
         $display("FAIL split_remaining: got %0d required 52", remaining);
      end
   endtask

   task automatic test_mode_change();
      exp_t e, g;
      int lat;
      logic [3:0] c1, c2;
      test = TM_SIMPLE;
      tick();
      for (int k = 0; k < 2; k++) begin
         e.c1 = 4'd10; e.c2 = 4'd8;
         exp_q.push_back(e);
         deal(1'b0, lat, c1, c2);
         g = exp_q.pop_front();
         total++;
         if (c1 !== g.c1 || c2 !== g.c2) begin
            bad++;
            $display("FAIL mode_change%0d: got (%0d,%0d) required (%0d,%0d)", k, c1, c2, g.c1, g.c2);
         end
         test = TM_DOUBLE;
         tick();
         tick();
         test = TM_SIMPLE;
         tick();
      end
      test = 3'd6;
      e.c1 = 4'd0; e.c2 = 4'd0;
      exp_q.push_back(e);
      deal(1'b0, lat, c1, c2);
      g = exp_q.pop_front();
      total++;
      if (c1 !== g.c1 || c2 !== g.c2 || lat != 1) begin
         bad++;
         $display("FAIL illegal_mode: got (%0d,%0d) lat %0d required (0,0) lat 1", c1, c2, lat);
      end
   endtask

   task automatic test_random_shoe();
      int lat, s, v0;
      logic [3:0] c1, c2;
      int vc [11];
      for (int v = 0; v < 11; v++) vc[v] = 0;
      do_reset();
      test = TM_BASE;
      tick();
      for (int k = 1; k <= 19; k++) begin
         deal(1'b1, lat, c1, c2);
         total++;
         if (lat < 3 || lat > 35) begin
            bad++;
            $display("FAIL rand_latency%0d: got %0d required 3..35", k, lat);
         end
         total++;
         if (c1 < 4'd1 || c1 > 4'd10 || c2 < 4'd1 || c2 > 4'd10) begin
            bad++;
            $display("FAIL rand_range%0d: got (%0d,%0d) required 1..10", k, c1, c2);
         end else begin
            vc[c1]++;
            vc[c2]++;
         end
         total++;
         if (int'(remaining) != 52 - 2*k) begin
            bad++;
            $display("FAIL rand_remaining%0d: got %0d required %0d", k, remaining, 52 - 2*k);
         end
         for (int v = 1; v <= 9; v++) begin
            total++;
            if (vc[v] > 4 || int'(dut.cnt_q[v-1]) != 4 - vc[v]) begin
               bad++;
               $display("FAIL rand_rank%0d_deal%0d: counter %0d dealt %0d required sum 4", v, k, dut.cnt_q[v-1], vc[v]);
            end
         end
         s = 0;
         for (int r = 9; r < 13; r++) s += int'(dut.cnt_q[r]);
         total++;
         if (vc[10] > 16 || s != 16 - vc[10]) begin
            bad++;
            $display("FAIL rand_tens_deal%0d: counters %0d dealt %0d required sum 16", k, s, vc[10]);
         end
      end
      // IDLE with 14 left: this req is dropped in favour of the reshuffle
      v0 = vcount;
      req = 1'b1; two = 1'b0;
      tick();
      req = 1'b0;
      total++;
      if (shuffled !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL shuffle_pulse: got shuffled=%b busy=%b required 1 1", shuffled, busy);
      end
      tick();
      total++;
      if (remaining !== 6'd52 || shuffled !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL shuffle_refill: got rem=%0d shuffled=%b busy=%b required 52 0 0", remaining, shuffled, busy);
      end
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (vcount != v0) begin
         bad++;
         $display("FAIL shuffle_req_dropped: got %0d valids required 0", vcount - v0);
      end
   endtask

   task automatic test_fallback();
      int lat;
      logic [3:0] c1, c2;
      logic [77:0] kings;
      kings = {6'd4, 72'd0};
      do_reset();
      test = TM_BASE;
      force dut.cnt_q = kings;
      tick();
      deal(1'b0, lat, c1, c2);
      total++;
      if (c1 !== 4'd10 || c2 !== 4'd0) begin
         bad++;
         $display("FAIL fallback_card: got (%0d,%0d) required (10,0)", c1, c2);
      end
      total++;
      if (lat < 2 || lat > 18) begin
         bad++;
         $display("FAIL fallback_latency: got %0d required 2..18", lat);
      end
      release dut.cnt_q;
      do_reset();
   endtask

   task automatic test_reset_mid_deal();
      int n, v0;
      do_reset();
      test = TM_BASE;
      req = 1'b1; two = 1'b1;
      tick();
      req = 1'b0;
      n = 0;
      while (dut.state_q != ST_DRAW2 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (dut.state_q != ST_DRAW2) begin
         bad++;
         $display("FAIL reach_draw2: got state %0d required %0d", dut.state_q, ST_DRAW2);
      end
      v0 = vcount;
      reset = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      total++;
      if (vcount != v0 || {card1_out, card2_out, valid, busy, shuffled} !== 11'd0 || remaining !== 6'd52) begin
         bad++;
         $display("FAIL reset_mid_deal: got valids=%0d outs=%h rem=%0d required 0 0 52",
                  vcount - v0, {card1_out, card2_out, valid, busy, shuffled}, remaining);
      end
   endtask

   task automatic test_busy();
      int nv;
      do_reset();
      test = TM_BJ;
      tick();
      nv = 0;
      req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (valid === 1'b1) begin
            nv++;
            total++;
            if (card1_out !== 4'd10 || card2_out !== 4'd1) begin
               bad++;
               $display("FAIL busy_cards%0d: got (%0d,%0d) required (10,1)", i, card1_out, card2_out);
            end
         end
         total++;
         if (valid !== ((i % 2) == 0)) begin
            bad++;
            $display("FAIL busy_pattern%0d: got valid=%b required %b", i, valid, (i % 2) == 0);
         end
      end
      req = 1'b0;
      total++;
      if (nv != 5) begin
         bad++;
         $display("FAIL busy_count: got %0d required 5", nv);
      end
   endtask

   initial begin
      test_reset();
      test_split();
      test_mode_change();
      test_random_shoe();
      test_fallback();
      test_reset_mid_deal();
      test_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
